// File: rtl/spi_bus_sequencer.sv
// Round-robin sequencer that runs four requesters' byte transactions
// on the shared SPI master register port.
module spi_bus_sequencer #(
    parameter logic [7:0] CMD_START = 8'h01,
    parameter int         BUSY_BIT  = 0,
    parameter int         TIMEOUT   = 255
) (
    input  logic        PCLK,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] req_cfg,
    input  logic [31:0] req_tx,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic [7:0]  rx_data,
    output logic        timeout_err,
    output logic        busy,
    output logic [3:0]  o_WR,
    output logic [3:0]  o_DR,
    output logic [7:0]  o_PWDATA,
    input  logic [7:0]  i_PRDATA
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, CFG, TX, CMD, POLL, CHK, RXRD, CAP, DONE
    } state_t;

    state_t     state, state_d;
    logic [1:0] idx, idx_d;
    logic [1:0] rr_ptr, rr_ptr_d;
    logic [5:0] cfg_q, cfg_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] poll_cnt, poll_cnt_d;
    logic       to_flag, to_flag_d;

    logic [3:0] gnt_d, done_d, wr_d, dr_d;
    logic [7:0] rx_d, pwdata_d;
    logic       terr_d, busy_d;

    logic       found;
    logic [1:0] win;
    logic [1:0] cand;

    // First requester after rr_ptr wins; rr_ptr itself is searched last.
    always_comb begin
        found = 1'b0;
        win   = rr_ptr;
        cand  = '0;
        for (int i = 1; i <= 4; i++) begin
            cand = rr_ptr + 2'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state;
        idx_d      = idx;
        rr_ptr_d   = rr_ptr;
        cfg_d      = cfg_q;
        tx_d       = tx_q;
        poll_cnt_d = poll_cnt;
        to_flag_d  = to_flag;
        rx_d       = rx_data;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_d   = CFG;
                    idx_d     = win;
                    rr_ptr_d  = win;
                    cfg_d     = req_cfg[8*win+2 +: 6];
                    tx_d      = req_tx[8*win +: 8];
                    to_flag_d = 1'b0;
                end
            end
            CFG:  state_d = TX;
            TX:   state_d = CMD;
            CMD: begin
                poll_cnt_d = '0;
                state_d    = POLL;
            end
            POLL: state_d = CHK;
            CHK: begin
                if (!i_PRDATA[BUSY_BIT]) begin
                    state_d = RXRD;
                end else if (poll_cnt < TO_LAST) begin
                    poll_cnt_d = poll_cnt + 8'd1;
                    state_d    = POLL;
                end else begin
                    to_flag_d = 1'b1;
                    state_d   = DONE;
                end
            end
            RXRD: state_d = CAP;
            CAP: begin
                rx_d    = i_PRDATA;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they align with it once registered.
    always_comb begin
        wr_d     = '0;
        dr_d     = '0;
        pwdata_d = o_PWDATA;
        busy_d   = (state_d != IDLE);
        gnt_d    = busy_d ? (4'b0001 << idx_d) : 4'b0000;
        done_d   = (state_d == DONE) ? (4'b0001 << idx_d) : 4'b0000;
        terr_d   = (state_d == DONE) && to_flag_d;
        unique case (state_d)
            CFG: begin
                wr_d     = 4'b0001;
                pwdata_d = {cfg_d, idx_d};
            end
            TX: begin
                wr_d     = 4'b0010;
                pwdata_d = tx_d;
            end
            CMD: begin
                wr_d     = 4'b1000;
                pwdata_d = CMD_START;
            end
            POLL:    dr_d = 4'b0001;
            RXRD:    dr_d = 4'b0010;
            default: ;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            rr_ptr      <= 2'd3;
            cfg_q       <= '0;
            tx_q        <= '0;
            poll_cnt    <= '0;
            to_flag     <= 1'b0;
            gnt         <= '0;
            done        <= '0;
            rx_data     <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            o_WR        <= '0;
            o_DR        <= '0;
            o_PWDATA    <= '0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            rr_ptr      <= rr_ptr_d;
            cfg_q       <= cfg_d;
            tx_q        <= tx_d;
            poll_cnt    <= poll_cnt_d;
            to_flag     <= to_flag_d;
            gnt         <= gnt_d;
            done        <= done_d;
            rx_data     <= rx_d;
            timeout_err <= terr_d;
            busy        <= busy_d;
            o_WR        <= wr_d;
            o_DR        <= dr_d;
            o_PWDATA    <= pwdata_d;
        end
    end

endmodule

// File: tb/tb_spi_bus_sequencer.sv
// Self-checking bench for spi_bus_sequencer: SPI master model plus
// a transaction-level reference for arbitration, bytes and latency.
module tb_spi_bus_sequencer;

    localparam int TB_TO = 4;

    logic        PCLK = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_cfg, req_tx;
    logic [3:0]  gnt, done;
    logic [7:0]  rx_data;
    logic        timeout_err, busy;
    logic [3:0]  o_WR, o_DR;
    logic [7:0]  o_PWDATA;
    logic [7:0]  i_PRDATA;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pcount = 0;
    int gi = 0;
    int strobe_viol = 0;
    int gnt_viol = 0;
    int nbusy[4];
    logic [7:0] rxv[4];

    typedef struct {
        int         arb;
        int         dcyc;
        int         ndr0;
        int         ndr1;
        logic [7:0] wr0, wr1, wr3, rx;
        logic [3:0] dvec, dgnt, idle_gnt;
        logic       terr;
        logic       ok;
    } txn_t;

    always #5 PCLK = ~PCLK;

    spi_bus_sequencer #(.CMD_START(8'h01), .BUSY_BIT(0), .TIMEOUT(TB_TO)) dut (
        .PCLK(PCLK), .rst(rst), .req(req), .req_cfg(req_cfg), .req_tx(req_tx),
        .gnt(gnt), .done(done), .rx_data(rx_data), .timeout_err(timeout_err),
        .busy(busy), .o_WR(o_WR), .o_DR(o_DR), .o_PWDATA(o_PWDATA),
        .i_PRDATA(i_PRDATA)
    );

    always @(posedge PCLK) cyc <= cyc + 1;

    // SPI master: busy for nbusy[granted] polls after each start command.
    always @(negedge PCLK) begin
        gi = 0;
        for (int i = 0; i < 4; i++) if (gnt[i]) gi = i;
        if (o_WR[3]) pcount = 0;
        if (o_DR[0]) begin
            i_PRDATA = {7'($urandom), pcount < nbusy[gi]};
            pcount++;
        end
        if (o_DR[1]) i_PRDATA = rxv[gi];
        if (($countones(o_WR) + $countones(o_DR)) > 1 || o_WR[2] || o_DR[3:2] != 2'b00)
            strobe_viol++;
        if ($countones(gnt) > 1 || (done & ~gnt) != 4'b0000)
            gnt_viol++;
    end

    task automatic do_reset;
        rst = 1'b1;
        req = 4'b0000;
        @(negedge PCLK);
        @(negedge PCLK);
        rst = 1'b0;
    endtask

    task automatic collect(input bit drop, input bit scramble, output txn_t t);
        logic [3:0] pg;
        t = '{arb: -100, dcyc: 0, ndr0: 0, ndr1: 0, wr0: 8'hxx, wr1: 8'hxx,
              wr3: 8'hxx, rx: 8'hxx, dvec: 4'h0, dgnt: 4'h0, idle_gnt: 4'hx,
              terr: 1'bx, ok: 1'b0};
        pg = gnt;
        for (int n = 0; n < 300; n++) begin
            @(negedge PCLK);
            if (o_WR[0]) begin
                t.arb = cyc - 1;
                t.wr0 = o_PWDATA;
                t.idle_gnt = pg;
                if (scramble) begin
                    req_cfg = $urandom;
                    req_tx  = $urandom;
                end
            end
            if (o_WR[1]) t.wr1 = o_PWDATA;
            if (o_WR[3]) t.wr3 = o_PWDATA;
            if (o_DR[0]) t.ndr0++;
            if (o_DR[1]) t.ndr1++;
            if (done != 4'b0000) begin
                t.dvec = done;
                t.dgnt = gnt;
                t.dcyc = cyc;
                t.terr = timeout_err;
                t.rx   = rx_data;
                t.ok   = 1'b1;
                if (drop) req = req & ~done;
                break;
            end
            pg = gnt;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = 4'b0000;
        req_cfg = '0;
        req_tx = '0;
        i_PRDATA = '0;
        @(negedge PCLK);
        @(negedge PCLK);
        checks++;
        if ({gnt, done, timeout_err, busy} !== 10'b0) begin
            errors++;
            $display("FAIL reset_ctrl got gnt=%b done=%b terr=%b busy=%b exp all 0",
                     gnt, done, timeout_err, busy);
        end
        checks++;
        if ({o_WR, o_DR, o_PWDATA, rx_data} !== 24'b0) begin
            errors++;
            $display("FAIL reset_port got wr=%b dr=%b pw=%h rx=%h exp all 0",
                     o_WR, o_DR, o_PWDATA, rx_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_single;
        txn_t t;
        req_cfg = 32'h0000_00A4;
        req_tx  = 32'h0000_005A;
        nbusy[0] = 0;
        rxv[0] = 8'hF0;
        req = 4'b0001;
        collect(1, 0, t);
        checks++;
        if (t.ok !== 1'b1) begin errors++; $display("FAIL single_done got none exp done"); end
        checks++;
        if (t.wr0 !== 8'hA4) begin errors++; $display("FAIL single_wr0 got=%h exp=a4", t.wr0); end
        checks++;
        if (t.wr1 !== 8'h5A) begin errors++; $display("FAIL single_wr1 got=%h exp=5a", t.wr1); end
        checks++;
        if (t.wr3 !== 8'h01) begin errors++; $display("FAIL single_wr3 got=%h exp=01", t.wr3); end
        checks++;
        if (t.dcyc - t.arb !== 8) begin
            errors++; $display("FAIL single_latency got=%0d exp=8", t.dcyc - t.arb);
        end
        checks++;
        if ({t.dvec, t.dgnt, t.rx, t.terr} !== {4'b0001, 4'b0001, 8'hF0, 1'b0}) begin
            errors++;
            $display("FAIL single_result got done=%b gnt=%b rx=%h terr=%b exp 0001 0001 f0 0",
                     t.dvec, t.dgnt, t.rx, t.terr);
        end
    endtask

    task automatic test_busy_polls;
        txn_t t;
        req_cfg = 32'h0000_0000;
        req_tx  = 32'h0000_3300;
        nbusy[1] = 3;
        rxv[1] = 8'hF1;
        req = 4'b0010;
        collect(1, 0, t);
        checks++;
        if (t.wr0 !== 8'h01) begin errors++; $display("FAIL busy_wr0 got=%h exp=01", t.wr0); end
        checks++;
        if (t.ndr0 !== 4) begin errors++; $display("FAIL busy_ndr0 got=%0d exp=4", t.ndr0); end
        checks++;
        if (t.dcyc - t.arb !== 14) begin
            errors++; $display("FAIL busy_latency got=%0d exp=14", t.dcyc - t.arb);
        end
        checks++;
        if ({t.dvec, t.rx} !== {4'b0010, 8'hF1}) begin
            errors++; $display("FAIL busy_result got done=%b rx=%h exp 0010 f1", t.dvec, t.rx);
        end
    endtask

    task automatic test_timeout;
        txn_t t;
        logic [7:0] prev;
        prev = rx_data;
        nbusy[0] = 1000;
        rxv[0] = ~prev;
        req = 4'b0001;
        collect(1, 0, t);
        checks++;
        if ({t.ndr0, t.ndr1} !== {32'd4, 32'd0}) begin
            errors++; $display("FAIL timeout_polls got dr0=%0d dr1=%0d exp 4 0", t.ndr0, t.ndr1);
        end
        checks++;
        if ({t.dvec, t.terr} !== {4'b0001, 1'b1}) begin
            errors++; $display("FAIL timeout_flag got done=%b terr=%b exp 0001 1", t.dvec, t.terr);
        end
        checks++;
        if (t.rx !== prev) begin
            errors++; $display("FAIL timeout_rx got=%h exp=%h", t.rx, prev);
        end
        checks++;
        if (t.dcyc - t.arb !== 4 + 2 * TB_TO) begin
            errors++; $display("FAIL timeout_latency got=%0d exp=%0d", t.dcyc - t.arb, 4 + 2 * TB_TO);
        end
        nbusy[0] = 0;
    endtask

    task automatic test_pair;
        txn_t t0, t1;
        int extra;
        do_reset;
        for (int i = 0; i < 4; i++) nbusy[i] = 1;
        req = 4'b0101;
        collect(1, 0, t0);
        collect(1, 0, t1);
        checks++;
        if ({t0.dvec, t1.dvec} !== {4'b0001, 4'b0100}) begin
            errors++; $display("FAIL pair_order got %b,%b exp 0001,0100", t0.dvec, t1.dvec);
        end
        extra = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge PCLK);
            if (done != 4'b0000 || gnt != 4'b0000) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL pair_extra got=%0d exp=0", extra); end
    endtask

    task automatic test_back_to_back;
        txn_t t;
        int prev_d;
        logic [3:0] exp_v;
        do_reset;
        for (int i = 0; i < 4; i++) nbusy[i] = $urandom_range(0, 2);
        req = 4'b1111;
        prev_d = 0;
        for (int k = 0; k < 5; k++) begin
            collect(0, 0, t);
            exp_v = 4'b0001 << (k % 4);
            checks++;
            if (t.dvec !== exp_v) begin
                errors++; $display("FAIL b2b_order k=%0d got=%b exp=%b", k, t.dvec, exp_v);
            end
            if (k > 0) begin
                checks++;
                if (t.arb !== prev_d + 1 || t.idle_gnt !== 4'b0000) begin
                    errors++;
                    $display("FAIL b2b_gap k=%0d got arb=%0d gnt=%b exp arb=%0d gnt=0000",
                             k, t.arb, t.idle_gnt, prev_d + 1);
                end
            end
            prev_d = t.dcyc;
        end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid;
        txn_t t0, t1;
        bit hit;
        nbusy[2] = 1000;
        req = 4'b0100;
        hit = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge PCLK);
            if (o_DR[0]) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL rstmid_poll got none exp DR0 strobe"); end
        rst = 1'b1;
        @(negedge PCLK);
        checks++;
        if ({gnt, done, rx_data, timeout_err, busy, o_WR, o_DR, o_PWDATA} !== 34'b0) begin
            errors++;
            $display("FAIL rstmid_outputs got gnt=%b done=%b rx=%h terr=%b busy=%b wr=%b dr=%b pw=%h exp all 0",
                     gnt, done, rx_data, timeout_err, busy, o_WR, o_DR, o_PWDATA);
        end
        rst = 1'b0;
        nbusy[2] = 0;
        nbusy[3] = 0;
        req = 4'b1100;
        collect(1, 0, t0);
        collect(1, 0, t1);
        checks++;
        if ({t0.dvec, t1.dvec} !== {4'b0100, 4'b1000}) begin
            errors++; $display("FAIL rstmid_order got %b,%b exp 0100,1000", t0.dvec, t1.dvec);
        end
    endtask

    task automatic test_random;
        txn_t t;
        int ptr, w, nb, lat;
        logic [3:0] mask;
        logic [7:0] ecfg, etx, last_rx, erx;
        do_reset;
        ptr = 3;
        last_rx = 8'h00;
        for (int r = 0; r < 8; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                nbusy[i] = $urandom_range(0, 5);
                rxv[i] = 8'($urandom);
            end
            req_cfg = $urandom;
            req_tx = $urandom;
            req = mask;
            while (mask != 4'b0000) begin
                w = -1;
                for (int k = 1; k <= 4; k++)
                    if (w < 0 && mask[(ptr + k) % 4]) w = (ptr + k) % 4;
                ecfg = req_cfg[8*w +: 8];
                etx = req_tx[8*w +: 8];
                nb = nbusy[w];
                collect(1, 1, t);
                lat = (nb >= TB_TO) ? 4 + 2 * TB_TO : 8 + 2 * nb;
                erx = (nb >= TB_TO) ? last_rx : rxv[w];
                checks++;
                if (t.ok !== 1'b1 || t.dvec !== (4'b0001 << w)) begin
                    errors++; $display("FAIL rand_grant got=%b exp=%b", t.dvec, 4'b0001 << w);
                    req = 4'b0000;
                    return;
                end
                checks++;
                if ({t.wr0, t.wr1, t.wr3} !== {ecfg[7:2], 2'(w), etx, 8'h01}) begin
                    errors++;
                    $display("FAIL rand_writes got %h %h %h exp %h %h 01",
                             t.wr0, t.wr1, t.wr3, {ecfg[7:2], 2'(w)}, etx);
                end
                checks++;
                if (t.dcyc - t.arb !== lat) begin
                    errors++; $display("FAIL rand_latency got=%0d exp=%0d", t.dcyc - t.arb, lat);
                end
                checks++;
                if (t.ndr0 !== ((nb >= TB_TO) ? TB_TO : nb + 1) || t.ndr1 !== ((nb >= TB_TO) ? 0 : 1)) begin
                    errors++; $display("FAIL rand_polls got dr0=%0d dr1=%0d nb=%0d", t.ndr0, t.ndr1, nb);
                end
                checks++;
                if ({t.rx, t.terr} !== {erx, nb >= TB_TO}) begin
                    errors++;
                    $display("FAIL rand_result got rx=%h terr=%b exp rx=%h terr=%b",
                             t.rx, t.terr, erx, nb >= TB_TO);
                end
                last_rx = erx;
                mask[w] = 1'b0;
                ptr = w;
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_invariants;
        checks++;
        if (strobe_viol !== 0) begin
            errors++; $display("FAIL strobe_onehot got=%0d exp=0", strobe_viol);
        end
        checks++;
        if (gnt_viol !== 0) begin
            errors++; $display("FAIL gnt_onehot got=%0d exp=0", gnt_viol);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            nbusy[i] = 0;
            rxv[i] = 8'h00;
        end
        test_reset;
        test_single;
        test_busy_polls;
        test_timeout;
        test_pair;
        test_back_to_back;
        test_reset_mid;
        test_random;
        test_invariants;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_bus_sequencer.md
Name: spi_bus_sequencer

Overview:
Sequences complete byte transactions on the shared SPI master register port (WR0..WR3 strobes, DR0..DR3 strobes, 8-bit write/read data). Four requesters each own one slave select (requester i ↔ SS i). The block arbitrates round-robin among them and runs each transaction as: config write, TX write, start command, status poll, RX read. It sits between the client logic and the SPI master, and is the only driver of the master's register port.

Parameters:
CMD_START, 8'h01, byte written through WR3 to launch a transfer
BUSY_BIT, 0, bit index of the busy flag in the STATE byte read through DR0
TIMEOUT, 255, maximum number of status polls per transaction (8-bit counter)

Ports:
PCLK  in  1  clock
rst  in  1  synchronous reset, active-high
req  in  4  per-requester transaction request, level; held until done[i]
req_cfg  in  32  requester i config byte at [8i+7:8i]
req_tx  in  32  requester i TX byte at [8i+7:8i]
gnt  out  4  one-hot grant, high for the whole granted transaction
done  out  4  one-cycle pulse on the granted requester at transaction end
rx_data  out  8  last received byte; valid when done pulses
timeout_err  out  1  one-cycle pulse, coincident with done, on poll timeout
busy  out  1  high whenever the FSM is not IDLE
o_WR  out  4  one-hot write strobes: [0] CONFIG, [1] TX, [2] unused (0), [3] CMD
o_DR  out  4  one-hot read strobes: [0] STATE, [1] RX, [3:2] unused (0)
o_PWDATA  out  8  write data, valid in the strobe cycle
i_PRDATA  in  8  read data from master, sampled one cycle after the DR strobe

Behaviour:
- All outputs are registered. Reset values: gnt=0, done=0, rx_data=8'h00, timeout_err=0, busy=0, o_WR=0, o_DR=0, o_PWDATA=0; FSM=IDLE; rr_ptr=3; poll_cnt=0.
- Arbitration happens in IDLE when req!=0. Search order is rr_ptr+1, rr_ptr+2, … mod 4. The first set bit wins: idx latched, rr_ptr<=idx. The cfg and tx bytes for idx are latched in the same cycle. Later changes on req_cfg/req_tx are ignored.
- FSM states, one cycle each unless noted:
  - IDLE → CFG on a winning request.
  - CFG: o_WR[0]=1, o_PWDATA={cfg[7:2], idx[1:0]}, so the slave-select field is forced to the requester index. gnt[idx]=1 from here through DONE.
  - TX: o_WR[1]=1, o_PWDATA=tx.
  - CMD: o_WR[3]=1, o_PWDATA=CMD_START, poll_cnt<=0. The master raises busy no later than the cycle after the CMD write.
  - POLL: o_DR[0]=1.
  - CHK: sample i_PRDATA.
    - If bit BUSY_BIT=1 and poll_cnt<TIMEOUT-1: poll_cnt+1 → POLL.
    - If bit BUSY_BIT=1 and poll_cnt=TIMEOUT-1: → DONE with the timeout flag set.
    - If bit BUSY_BIT=0: → RXRD.
  - RXRD: o_DR[1]=1.
  - CAP: rx_data<=i_PRDATA.
  - DONE: done[idx]=1; timeout_err=1 if the timeout flag is set (rx_data unchanged); → IDLE. gnt clears on entry to IDLE.
- Minimum latency, with no busy in the first poll: IDLE arbitration cycle k → done at k+8. Each additional busy poll adds 2 cycles.
- Strobes: at most one o_WR/o_DR bit is high in any cycle. o_PWDATA holds its last value outside write cycles.
- Simultaneous requests resolve via rr_ptr. With all four held continuously, grant order is 0,1,2,3,0,…
- Dropping req mid-transaction does not abort it: done still pulses and the requester is responsible for ignoring it. A requester still holding req in the cycle after done is eligible again, subject to round-robin.
- New requests during a transaction are not granted until the FSM returns to IDLE. There is no preemption.
- rst asserted in any state takes effect in the same cycle: in the following cycle every output is at its reset value, with no partial strobe, done or grant. rr_ptr returns to 3.
- Unused strobe bits o_WR[2] and o_DR[3:2] are tied to 0.

Test Plan:
1. Reset, then req=4'b0001, cfg0=8'hA4, tx0=8'h5A; master returns STATE=00 on the first poll and RX=8'hF0. Required:
   - WR0 with PWDATA=8'hA4 (low bits forced to 00), then WR1 with 8'h5A, then WR3 with 8'h01.
   - done[0] exactly 8 cycles after arbitration; rx_data=8'hF0; timeout_err=0.
2. req=4'b0010, cfg1=8'h00; master busy for 3 polls then idle, RX=8'hF1. Required: CONFIG write is 8'h01; exactly 4 DR0 strobes; done[1] at +14; rx_data=8'hF1.
3. req=4'b0101 asserted simultaneously after reset. Required: requester 0 is granted first, then 2; gnt is never two-hot; each gets exactly one done pulse.
4. req=4'b1111 held for 5 transactions. Required: grant order 0,1,2,3,0; gnt low for one IDLE cycle between transactions.
5. STATE busy forever, TIMEOUT=4. Required: exactly 4 DR0 strobes, then done and timeout_err pulse together; rx_data keeps its previous value; no DR1 strobe.
6. rst asserted during POLL of requester 2's transaction. Required: the next cycle has all outputs 0 and busy=0; after release, with req=4'b1100, requester 2 is granted first (rr_ptr=3).
